// File: rtl/gelu_seq_pkg.sv
// Shared types and constants for the GELU row sequencer.
// Rows are 32 int8 lanes; the default scales are the usual encoder-layer values.
package gelu_seq_pkg;

    localparam int ROW_LANES = 32;
    localparam int LANE_W    = 8;

    localparam logic [15:0] DEF_IN_SCALE  = 16'd2005;
    localparam logic [15:0] DEF_OUT_SCALE = 16'd1072;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

    typedef struct packed {
        seq_state_t state;
        logic [1:0] fifo_count;
        logic       fifo_full;
        logic       fifo_empty;
        logic       rd_pending;
    } seq_dbg_t;

endpackage

// File: rtl/gelu_prefetch_fifo.sv
// Two-entry row FIFO between the source buffer read port and the GELU input.
// Pop is only issued on a non-empty FIFO and push only when the issue logic left room.
module gelu_prefetch_fifo #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/gelu_seq_ctrl.sv
// Streams a block of int8 rows from the source buffer through the shared GELU unit
// and writes the results, in order, to the destination buffer.
module gelu_seq_ctrl
    import gelu_seq_pkg::*;
#(
    parameter int DATA_W  = ROW_LANES * LANE_W,
    parameter int ADDR_W  = 10,
    parameter int SCALE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [ADDR_W-1:0]  cfg_src_base,
    input  logic [ADDR_W-1:0]  cfg_dst_base,
    input  logic [ADDR_W:0]    cfg_num_rows,
    input  logic [SCALE_W-1:0] cfg_in_scale,
    input  logic [SCALE_W-1:0] cfg_out_scale,
    output logic               busy,
    output logic               done,
    output logic               src_rd_en,
    output logic [ADDR_W-1:0]  src_rd_addr,
    input  logic [DATA_W-1:0]  src_rd_data,
    output logic               gelu_in_valid,
    input  logic               gelu_in_ready,
    output logic [DATA_W-1:0]  gelu_in_data,
    output logic [SCALE_W-1:0] gelu_in_scale,
    output logic [SCALE_W-1:0] gelu_out_scale,
    input  logic               gelu_out_valid,
    output logic               gelu_out_ready,
    input  logic [DATA_W-1:0]  gelu_out_data,
    output logic               dst_wr_en,
    output logic [ADDR_W-1:0]  dst_wr_addr,
    output logic [DATA_W-1:0]  dst_wr_data,
    output seq_dbg_t           dbg,
    output logic [ADDR_W:0]    dbg_in_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  src_base_q, dst_base_q;
    logic [ADDR_W:0]    num_rows_q;
    logic [SCALE_W-1:0] in_scale_q, out_scale_q;
    logic [ADDR_W:0]    rd_cnt_q, in_cnt_q, out_cnt_q, wr_cnt_q;
    logic               rd_pending_q;
    logic               done_q;
    logic               dst_wr_en_q;
    logic [ADDR_W-1:0]  dst_wr_addr_q;
    logic [DATA_W-1:0]  dst_wr_data_q;

    logic               start_acc, in_hs, out_hs;
    logic               fifo_full, fifo_empty;
    logic [1:0]         fifo_count;
    logic [2:0]         fifo_occ;

    gelu_prefetch_fifo #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pending_q),
        .din   (src_rd_data),
        .pop   (in_hs),
        .head  (gelu_in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Valid/ready: a transfer happens on a cycle where both are high; once
    // gelu_in_valid rises it and gelu_in_data hold until gelu_in_ready is seen.
    assign gelu_in_valid  = !fifo_empty;
    assign in_hs          = gelu_in_valid && gelu_in_ready;
    assign busy           = (state_q == RUN);
    assign gelu_out_ready = busy;
    assign out_hs         = gelu_out_valid && gelu_out_ready;
    assign start_acc      = (state_q == IDLE) && cfg_start;

    // Rows held or in flight, less the one leaving this cycle, must leave a free slot.
    assign fifo_occ    = {1'b0, fifo_count} + {2'b0, rd_pending_q} - {2'b0, in_hs};
    assign src_rd_en   = busy && (rd_cnt_q < num_rows_q) && (fifo_occ < 3'd2);
    assign src_rd_addr = src_base_q + rd_cnt_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_num_rows == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (dst_wr_en_q && ((wr_cnt_q + CNT_ONE) == num_rows_q)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            src_base_q    <= '0;
            dst_base_q    <= '0;
            num_rows_q    <= '0;
            in_scale_q    <= '0;
            out_scale_q   <= '0;
            rd_cnt_q      <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            rd_pending_q  <= 1'b0;
            done_q        <= 1'b0;
            dst_wr_en_q   <= 1'b0;
            dst_wr_addr_q <= '0;
            dst_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= src_rd_en;
            done_q       <= (state_q == FINISH);
            dst_wr_en_q  <= out_hs;
            if (start_acc) begin
                src_base_q  <= cfg_src_base;
                dst_base_q  <= cfg_dst_base;
                num_rows_q  <= cfg_num_rows;
                in_scale_q  <= cfg_in_scale;
                out_scale_q <= cfg_out_scale;
                rd_cnt_q    <= '0;
                in_cnt_q    <= '0;
                out_cnt_q   <= '0;
                wr_cnt_q    <= '0;
            end else begin
                if (src_rd_en)   rd_cnt_q  <= rd_cnt_q + CNT_ONE;
                if (in_hs)       in_cnt_q  <= in_cnt_q + CNT_ONE;
                if (out_hs)      out_cnt_q <= out_cnt_q + CNT_ONE;
                if (dst_wr_en_q) wr_cnt_q  <= wr_cnt_q + CNT_ONE;
            end
            // Address comes from the accepted-output count so back-to-back writes never collide.
            if (out_hs) begin
                dst_wr_addr_q <= dst_base_q + out_cnt_q[ADDR_W-1:0];
                dst_wr_data_q <= gelu_out_data;
            end
        end
    end

    assign done           = done_q;
    assign dst_wr_en      = dst_wr_en_q;
    assign dst_wr_addr    = dst_wr_addr_q;
    assign dst_wr_data    = dst_wr_data_q;
    assign gelu_in_scale  = in_scale_q;
    assign gelu_out_scale = out_scale_q;
    assign dbg_in_cnt     = in_cnt_q;
    assign dbg = '{state: state_q, fifo_count: fifo_count, fifo_full: fifo_full,
                   fifo_empty: fifo_empty, rd_pending: rd_pending_q};

endmodule

// File: tb/tb_gelu_seq_ctrl.sv
// Bench for gelu_seq_ctrl: source SRAM and GELU stub models, expected-write scoreboard.
// The GELU stub keeps non-negative lanes and arithmetic-shifts negative lanes right by 2.
module tb_gelu_seq_ctrl;
    import gelu_seq_pkg::*;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 10;
    localparam int SCALE_W = 16;
    localparam int EXP_W   = ADDR_W + DATA_W;

    localparam logic [DATA_W-1:0] ROW0_SRC  = {216'd0, 8'd30, 8'd25, 8'd24, 8'hF9, 8'd51};
    localparam logic [DATA_W-1:0] ROW0_GELU = {216'd0, 8'd30, 8'd25, 8'd24, 8'hFE, 8'd51};

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic [ADDR_W-1:0]  cfg_src_base, cfg_dst_base;
    logic [ADDR_W:0]    cfg_num_rows;
    logic [SCALE_W-1:0] cfg_in_scale, cfg_out_scale;
    logic               busy, done, src_rd_en;
    logic [ADDR_W-1:0]  src_rd_addr;
    logic [DATA_W-1:0]  src_rd_data;
    logic               gelu_in_valid, gelu_in_ready;
    logic [DATA_W-1:0]  gelu_in_data;
    logic [SCALE_W-1:0] gelu_in_scale, gelu_out_scale;
    logic               gelu_out_valid, gelu_out_ready;
    logic [DATA_W-1:0]  gelu_out_data;
    logic               dst_wr_en;
    logic [ADDR_W-1:0]  dst_wr_addr;
    logic [DATA_W-1:0]  dst_wr_data;
    seq_dbg_t           dbg;
    logic [ADDR_W:0]    dbg_in_cnt;

    gelu_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCALE_W(SCALE_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_num_rows(cfg_num_rows),
        .cfg_in_scale(cfg_in_scale), .cfg_out_scale(cfg_out_scale),
        .busy(busy), .done(done), .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
        .src_rd_data(src_rd_data), .gelu_in_valid(gelu_in_valid), .gelu_in_ready(gelu_in_ready),
        .gelu_in_data(gelu_in_data), .gelu_in_scale(gelu_in_scale), .gelu_out_scale(gelu_out_scale),
        .gelu_out_valid(gelu_out_valid), .gelu_out_ready(gelu_out_ready),
        .gelu_out_data(gelu_out_data), .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr),
        .dst_wr_data(dst_wr_data), .dbg(dbg), .dbg_in_cnt(dbg_in_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    logic [DATA_W-1:0] src_mem [0:1023];
    logic [EXP_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] rd_exp_q[$];
    logic [DATA_W-1:0] stub_q[$];

    int n_vec = 0, n_err = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, start_cyc = 0, busy_cnt = 0;
    int rd_total = 0, wr_total = 0, outstanding = 0, last_rd_cyc = 0, rdy_idx = 0;
    int rdy_mode = 0;
    logic [3:0]         rdy_pat = 4'b1001;
    logic               rec_rd = 1'b0, rec_out_hs = 1'b0, flush_req = 1'b0;
    logic               first_rd = 1'b0, b2b = 1'b0, prev_stall = 1'b0;
    logic [ADDR_W-1:0]  rec_rd_addr = '0;
    logic [DATA_W-1:0]  prev_data = '0;
    logic [SCALE_W-1:0] exp_in_scale = '0, exp_out_scale = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] gelu_row(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        logic signed [7:0] v;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            v = x[8*i +: 8];
            r[8*i +: 8] = (v < 0) ? (v >>> 2) : v;
        end
        return r;
    endfunction

    // ---------------- drivers: SRAM read data, GELU ready, GELU stub output ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (flush_req) begin
                stub_q.delete();
                exp_q.delete();
                rd_exp_q.delete();
                rec_rd = 1'b0;
                rec_out_hs = 1'b0;
                prev_stall = 1'b0;
                outstanding = 0;
                flush_req = 1'b0;
            end else if (rec_out_hs && stub_q.size() > 0) begin
                stub_q.delete(0);
            end
            src_rd_data    = rec_rd ? src_mem[rec_rd_addr] : '0;
            gelu_in_ready  = (rdy_mode == 0) ? 1'b1 : rdy_pat[rdy_idx % 4];
            rdy_idx++;
            gelu_out_valid = (stub_q.size() > 0);
            gelu_out_data  = (stub_q.size() > 0) ? stub_q[0] : '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic             hs_in;
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            hs_in = gelu_in_valid && gelu_in_ready;
            if (prev_stall) begin
                chk("stall_valid", gelu_in_valid, 1);
                chk("stall_data", gelu_in_data, prev_data);
            end
            prev_stall = gelu_in_valid && !gelu_in_ready;
            prev_data  = gelu_in_data;
            outstanding = outstanding + (src_rd_en ? 1 : 0) - (hs_in ? 1 : 0);
            if (src_rd_en) begin
                rd_total++;
                if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", src_rd_addr, rd_exp_q.pop_front());
                chk("rd_credit", outstanding <= 2, 1);
                if (first_rd) chk("rd_first_lat", cyc - start_cyc, 1);
                else if (b2b) chk("rd_b2b", cyc - last_rd_cyc, 1);
                first_rd = 1'b0;
                last_rd_cyc = cyc;
            end
            if (hs_in) begin
                chk("in_scale", gelu_in_scale, exp_in_scale);
                chk("out_scale", gelu_out_scale, exp_out_scale);
                stub_q.push_back(gelu_row(gelu_in_data));
            end
            if (dst_wr_en) begin
                wr_total++;
                if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", dst_wr_addr, e[EXP_W-1 -: ADDR_W]);
                    chk("wr_data", dst_wr_data, e[DATA_W-1:0]);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            rec_out_hs  = gelu_out_valid && gelu_out_ready;
            rec_rd      = src_rd_en;
            rec_rd_addr = src_rd_addr;
        end
    end

    // ---------------- stimulus tasks ----------------
    int done_base = 0;

    task automatic start_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                             input int n, input logic [SCALE_W-1:0] is, input logic [SCALE_W-1:0] os);
        logic [ADDR_W-1:0] a, d;
        @(negedge clk);
        #1;
        cfg_src_base  = src;
        cfg_dst_base  = dst;
        cfg_num_rows  = (ADDR_W+1)'(n);
        cfg_in_scale  = is;
        cfg_out_scale = os;
        cfg_start     = 1'b1;
        start_cyc     = cyc;
        first_rd      = 1'b1;
        exp_in_scale  = is;
        exp_out_scale = os;
        done_base     = done_cnt;
        for (int i = 0; i < n; i++) begin
            a = src + ADDR_W'(i);
            d = dst + ADDR_W'(i);
            rd_exp_q.push_back(a);
            exp_q.push_back({d, (a == '0) ? ROW0_GELU : gelu_row(src_mem[a])});
        end
        @(negedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_cnt == done_base && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done_cnt != done_base, 1);
        repeat (4) @(negedge clk);
        #3;
        chk("done_once", done_cnt - done_base, 1);
        chk("wr_q_empty", exp_q.size(), 0);
        chk("rd_q_empty", rd_exp_q.size(), 0);
        chk("in_cnt", dbg_in_cnt, (ADDR_W+1)'(n));
        chk("hold_in_scale", gelu_in_scale, exp_in_scale);
        chk("hold_out_scale", gelu_out_scale, exp_out_scale);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, src_rd_en, 0);
        chk({tag, "_rd_addr"}, src_rd_addr, 0);
        chk({tag, "_in_valid"}, gelu_in_valid, 0);
        chk({tag, "_in_data"}, gelu_in_data, 0);
        chk({tag, "_in_scale"}, gelu_in_scale, 0);
        chk({tag, "_out_scale"}, gelu_out_scale, 0);
        chk({tag, "_out_ready"}, gelu_out_ready, 0);
        chk({tag, "_wr_en"}, dst_wr_en, 0);
        chk({tag, "_wr_addr"}, dst_wr_addr, 0);
        chk({tag, "_wr_data"}, dst_wr_data, 0);
        chk({tag, "_state"}, dbg.state, IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r0, w0, b0, k;
        rst = 1'b0;
        cfg_start = 1'b0;
        cfg_src_base = '0;
        cfg_dst_base = '0;
        cfg_num_rows = '0;
        cfg_in_scale = '0;
        cfg_out_scale = '0;
        src_rd_data = '0;
        gelu_in_ready = 1'b1;
        gelu_out_valid = 1'b0;
        gelu_out_data = '0;
        for (int a = 0; a < 1024; a++) begin
            for (int l = 0; l < 32; l++) src_mem[a][8*l +: 8] = 8'(a * 7 + l * 29 + 3);
        end
        src_mem[0] = ROW0_SRC;

        repeat (3) @(negedge clk);
        #3;
        check_idle_zero("reset");
        #1 rst = 1'b1;

        // Four rows, GELU always ready: back-to-back reads and writes.
        rdy_mode = 0;
        b2b = 1'b1;
        start_job(10'd0, 10'd16, 4, DEF_IN_SCALE, DEF_OUT_SCALE);
        wait_done(4);
        b2b = 1'b0;

        // Same job with input ready toggling 1,0,0,1.
        rdy_mode = 1;
        rdy_idx = 0;
        start_job(10'd0, 10'd16, 4, DEF_IN_SCALE, DEF_OUT_SCALE);
        wait_done(4);
        rdy_mode = 0;

        // Empty job: done two cycles after start, no traffic, never busy.
        r0 = rd_total;
        w0 = wr_total;
        b0 = busy_cnt;
        start_job(10'd5, 10'd7, 0, DEF_IN_SCALE, DEF_OUT_SCALE);
        wait_done(0);
        chk("empty_done_lat", done_cyc - start_cyc, 2);
        chk("empty_reads", rd_total - r0, 0);
        chk("empty_writes", wr_total - w0, 0);
        chk("empty_busy", busy_cnt - b0, 0);

        // Address wrap on both buffers.
        start_job(10'd1022, 10'd1023, 3, DEF_IN_SCALE, DEF_OUT_SCALE);
        wait_done(3);

        // A second start while busy is dropped.
        start_job(10'd100, 10'd200, 6, 16'd1234, 16'd4321);
        @(negedge clk);
        #1;
        cfg_num_rows  = 11'd9;
        cfg_in_scale  = 16'd9;
        cfg_out_scale = 16'd9;
        cfg_src_base  = 10'd500;
        cfg_start     = 1'b1;
        @(negedge clk);
        #1 cfg_start = 1'b0;
        wait_done(6);
        repeat (12) @(negedge clk);
        chk("drop_no_second_done", done_cnt - done_base, 1);

        // Reset mid-job after two writes, then a clean restart.
        w0 = wr_total;
        start_job(10'd300, 10'd400, 8, DEF_IN_SCALE, DEF_OUT_SCALE);
        k = 0;
        while (wr_total - w0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("two_writes_seen", wr_total - w0 >= 2, 1);
        #1;
        rst = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        check_idle_zero("midrst");
        chk("midrst_in_cnt", dbg_in_cnt, 0);
        start_job(10'd300, 10'd400, 3, DEF_IN_SCALE, DEF_OUT_SCALE);
        wait_done(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
